// File: rtl/scan_mux_nw.sv
// Registered CHANNELS-to-1 lane multiplexer with a manual select mode and an
// auto-scan mode that dwells DWELL enable-ticks on each channel in turn.
module scan_mux_nw #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic [WIDTH*CHANNELS-1:0] Din,
  input  logic                      Mode,
  input  logic [SEL_W-1:0]          Sel,
  input  logic                      Enable,
  input  logic                      Hold,
  output logic [WIDTH-1:0]          M,
  output logic [SEL_W-1:0]          Chan,
  output logic                      Step,
  output logic                      Err
);

  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [SEL_W-1:0] nc;
  logic             err_next;
  logic             sel_ok;

  assign sel_ok = 32'(Sel) < CHANNELS;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    nc       = Chan;
    cnt_next = cnt;
    err_next = 1'b0;
    if (!Mode) begin
      // Manual select keeps the dwell counter cleared so a later switch to
      // auto mode always starts with a full dwell.
      cnt_next = '0;
      if (sel_ok) nc = Sel;
      else        err_next = 1'b1;
    end else if (Enable && !Hold) begin
      if (cnt == DWELL_LAST) begin
        cnt_next = '0;
        nc       = (Chan == LAST_CH) ? '0 : Chan + SEL_W'(1);
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt  <= '0;
      Chan <= '0;
      M    <= '0;
      Step <= 1'b0;
      Err  <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      Chan <= nc;
      M    <= Din[nc*WIDTH +: WIDTH];
      Step <= (nc != Chan);
      Err  <= err_next;
    end
  end

endmodule

// File: tb/tb_scan_mux_nw.sv
// Drives three differently parameterised scan_mux_nw instances from shared
// controls and compares them every cycle against a channel/tick model.
module tb_scan_mux_nw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic [2:0]  sel = '0;
  logic        en = 1'b0;
  logic        hold = 1'b0;
  logic [23:0] din_a = '0;
  logic [17:0] din_b = '0;
  logic [23:0] din_c = '0;

  logic [2:0] a_m, a_chan, b_m, b_chan, c_chan;
  logic [7:0] c_m;
  logic       a_step, a_err, b_step, b_err, c_step, c_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  scan_mux_nw #(.WIDTH(3), .CHANNELS(8), .SEL_W(3), .DWELL(4), .CNT_W(8)) dut_a (
    .Clock(clk), .Resetn(rst_n), .Din(din_a), .Mode(mode), .Sel(sel),
    .Enable(en), .Hold(hold), .M(a_m), .Chan(a_chan), .Step(a_step), .Err(a_err));

  scan_mux_nw #(.WIDTH(3), .CHANNELS(6), .SEL_W(3), .DWELL(4), .CNT_W(8)) dut_b (
    .Clock(clk), .Resetn(rst_n), .Din(din_b), .Mode(mode), .Sel(sel),
    .Enable(en), .Hold(hold), .M(b_m), .Chan(b_chan), .Step(b_step), .Err(b_err));

  scan_mux_nw #(.WIDTH(8), .CHANNELS(3), .SEL_W(3), .DWELL(1), .CNT_W(8)) dut_c (
    .Clock(clk), .Resetn(rst_n), .Din(din_c), .Mode(mode), .Sel(sel),
    .Enable(en), .Hold(hold), .M(c_m), .Chan(c_chan), .Step(c_step), .Err(c_err));

  typedef struct packed {
    int chan;
    int ticks;
    bit step;
    bit err;
  } model_t;

  model_t ma, mb, mc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane(input logic [31:0] din, input int k, input int w);
    logic [31:0] sh;
    sh = din >> (k * w);
    return sh & ((32'd1 << w) - 32'd1);
  endfunction

  // One edge of the behaviour: which channel is shown next and why.
  function automatic model_t advance(input model_t s, input int channels, input int dwell,
                                     input bit md, input int sl, input bit e, input bit h);
    model_t n;
    n = s;
    if (!md) begin
      n.ticks = 0;
      if (sl < channels) begin
        n.chan = sl;
        n.err  = 1'b0;
      end else begin
        n.err  = 1'b1;
      end
    end else begin
      n.err = 1'b0;
      if (e && !h) begin
        n.ticks = s.ticks + 1;
        if (n.ticks == dwell) begin
          n.ticks = 0;
          n.chan  = (s.chan + 1) % channels;
        end
      end
    end
    n.step = (n.chan != s.chan);
    return n;
  endfunction

  task automatic check_all();
    check("a.chan", 32'(a_chan), 32'(ma.chan));
    check("a.m",    32'(a_m),    lane(32'(din_a), ma.chan, 3));
    check("a.step", 32'(a_step), 32'(ma.step));
    check("a.err",  32'(a_err),  32'(ma.err));
    check("b.chan", 32'(b_chan), 32'(mb.chan));
    check("b.m",    32'(b_m),    lane(32'(din_b), mb.chan, 3));
    check("b.step", 32'(b_step), 32'(mb.step));
    check("b.err",  32'(b_err),  32'(mb.err));
    check("c.chan", 32'(c_chan), 32'(mc.chan));
    check("c.m",    32'(c_m),    lane(32'(din_c), mc.chan, 8));
    check("c.step", 32'(c_step), 32'(mc.step));
    check("c.err",  32'(c_err),  32'(mc.err));
  endtask

  // Called at a falling edge; drives inputs, lets one rising edge pass,
  // checks just after it, and returns at the next falling edge.
  task automatic cyc(input bit md, input int sl, input bit e, input bit h, input bit rnd);
    mode = md;
    sel  = sl[2:0];
    en   = e;
    hold = h;
    if (rnd) begin
      din_a = 24'($urandom);
      din_b = 18'($urandom);
      din_c = 24'($urandom);
    end
    ma = advance(ma, 8, 4, md, sl, e, h);
    mb = advance(mb, 6, 4, md, sl, e, h);
    mc = advance(mc, 3, 1, md, sl, e, h);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks that it acts without a clock.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check("rst.a.chan", 32'(a_chan), 32'd0);
    check("rst.a.m",    32'(a_m),    32'd0);
    check("rst.a.step", 32'(a_step), 32'd0);
    check("rst.b.err",  32'(b_err),  32'd0);
    check("rst.c.m",    32'(c_m),    32'd0);
    ma = '0;
    mb = '0;
    mc = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    ma = '0;
    mb = '0;
    mc = '0;
    for (int k = 0; k < 8; k++) din_a[k*3 +: 3] = 3'(k);
    for (int k = 0; k < 6; k++) din_b[k*3 +: 3] = 3'(k);
    for (int k = 0; k < 3; k++) din_c[k*8 +: 8] = 8'(k);
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Manual select of channel 5, then a lane change seen one cycle later.
    cyc(0, 5, 0, 0, 0);
    check("man.a.m5", 32'(a_m), 32'h5);
    cyc(0, 5, 0, 0, 0);
    din_a[15 +: 3] = 3'b010;
    cyc(0, 5, 0, 0, 0);
    check("man.a.m5b", 32'(a_m), 32'h2);

    // Reset mid-activity, then a full auto scan with wrap.
    do_reset();
    for (int k = 0; k < 8; k++) din_a[k*3 +: 3] = 3'(k);
    for (int i = 0; i < 36; i++) cyc(1, 0, 1, 0, 0);
    check("auto.a.wrap", 32'(a_chan), 32'd1);

    // Enable every third cycle, then Hold overriding Enable.
    for (int i = 0; i < 30; i++) cyc(1, 0, (i % 3) == 2, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, 0, 0);

    // Out-of-range manual select on the 6-channel instance.
    cyc(0, 2, 0, 0, 1);
    cyc(0, 7, 0, 0, 1);
    check("oor.b.err", 32'(b_err), 32'd1);
    check("oor.b.chan", 32'(b_chan), 32'd2);
    cyc(0, 7, 0, 0, 1);
    cyc(0, 4, 0, 0, 1);
    check("oor.b.chan4", 32'(b_chan), 32'd4);

    // Mode switch mid-dwell, then reset at channel 6.
    do_reset();
    for (int i = 0; i < 14; i++) cyc(1, 0, 1, 0, 0);
    cyc(0, 3, 0, 0, 0);
    check("sw.a.nostep", 32'(a_step), 32'd0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0, 0);
    for (int i = 0; i < 40 && ma.chan != 6; i++) cyc(1, 0, 1, 0, 0);
    check("sw.a.at6", 32'(a_chan), 32'd6);
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 0);

    // Wide lanes on the 3-channel, single-tick instance.
    din_c[16 +: 8] = 8'hA5;
    cyc(0, 2, 0, 0, 0);
    check("wide.c.a5", 32'(c_m), 32'hA5);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0);

    // Random mixture of everything, with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      cyc(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
